// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: memory-arbiter owner states, default bus widths
// and the opcode/type constants the pipeline decodes with.
package mips32_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    I_OWN,
    D_OWN
  } owner_e;

  typedef enum logic [1:0] {
    ITYPE_R,
    ITYPE_I,
    ITYPE_J
  } instr_type_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  function automatic instr_type_e op_type(input logic [5:0] op);
    case (op)
      OP_RTYPE:      return ITYPE_R;
      OP_J, OP_JAL:  return ITYPE_J;
      default:       return ITYPE_I;
    endcase
  endfunction

endpackage

// File: rtl/mips32_mem_arb_if.sv
// Bundle of fetch, data and single-port memory signals around the arbiter;
// slave is the arbiter view, master is the requester/memory view.
interface mips32_mem_arb_if
  import mips32_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              halt;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  halt, i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output halt, i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mips32_starve_ctr.sv
// Counts data grants issued while a fetch waits; flags when fetch must win.
module mips32_starve_ctr
  import mips32_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  localparam int CNT_W = $clog2(STARVE_MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req_i,
  input  logic i_gnt_i,
  input  logic d_gnt_i,
  output logic starve_hit_o
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_gnt_i || !i_req_i) begin
      cnt_d = '0;
    end else if (d_gnt_i && (cnt_q != MaxCnt)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starve_hit_o = i_req_i && (cnt_q == MaxCnt);

endmodule

// File: rtl/mips32_mem_arb.sv
// Single-port memory arbiter between fetch and data ports, data has priority.
// Define MIPS32_ARB_FAIRNESS_EN to let a starved fetch win after STARVE_MAX data grants.
module mips32_mem_arb
  import mips32_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  mips32_mem_arb_if.slave    bus
);

  owner_e            state_q, state_d;
  logic              rd_pend_q, rd_pend_d;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
  logic              i_gnt, d_gnt, i_wins, can_grant;
  logic              i_rvalid, d_rvalid;

`ifdef MIPS32_ARB_FAIRNESS_EN
  mips32_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk          (clk),
    .rst          (rst),
    .i_req_i      (bus.i_req),
    .i_gnt_i      (i_gnt),
    .d_gnt_i      (d_gnt),
    .starve_hit_o (i_wins)
  );
`else
  assign i_wins = 1'b0;
`endif

  always_comb begin
    can_grant = !rst && !bus.halt;
    d_gnt     = can_grant && bus.d_req && !(bus.i_req && i_wins);
    i_gnt     = can_grant && bus.i_req && !d_gnt;
  end

  // Owner is the last grantee; rd_pend_q marks whether that grant was a read.
  always_comb begin
    state_d   = IDLE;
    rd_pend_d = 1'b0;
    if (i_gnt) begin
      state_d   = I_OWN;
      rd_pend_d = 1'b1;
    end else if (d_gnt) begin
      state_d   = D_OWN;
      rd_pend_d = !bus.d_we;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_pend_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= rd_pend_d;
      if (i_rvalid) i_rdata_q <= bus.mem_rdata;
      if (d_rvalid) d_rdata_q <= bus.mem_rdata;
    end
  end

  // Gating with rst drops a read whose return collides with reset.
  assign i_rvalid = !rst && rd_pend_q && (state_q == I_OWN);
  assign d_rvalid = !rst && rd_pend_q && (state_q == D_OWN);

  assign bus.i_gnt     = i_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.i_rvalid  = i_rvalid;
  assign bus.d_rvalid  = d_rvalid;
  assign bus.i_rdata   = i_rvalid ? bus.mem_rdata : i_rdata_q;
  assign bus.d_rdata   = d_rvalid ? bus.mem_rdata : d_rdata_q;
  assign bus.mem_en    = i_gnt || d_gnt;
  assign bus.mem_we    = d_gnt && bus.d_we;
  assign bus.mem_addr  = d_gnt ? bus.d_addr : bus.i_addr;
  assign bus.mem_wdata = bus.d_wdata;

endmodule

// File: doc/mips32_mem_arb.md
MIPS32_MEM_ARB -- requirements
Module: mips32_mem_arb

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width (1024-word memory).
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter STARVE_MAX, default 4, maximum consecutive data grants while an instruction request waits.
REQ-004 Ports (clock and reset first; name, direction, width, meaning):
- clk  in  1  single clock; all state on posedge.
- rst  in  1  synchronous, active-high reset.
- halt  in  1  blocks new grants; in-flight reads still return.
- i_req  in  1  fetch request.
- i_addr  in  ADDR_W  fetch address.
- i_gnt  out  1  fetch accepted this cycle.
- i_rvalid  out  1  i_rdata valid.
- i_rdata  out  DATA_W  fetched word.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data access accepted this cycle.
- d_rvalid  out  1  d_rdata valid (loads only).
- d_rdata  out  DATA_W  loaded word.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after mem_en with mem_we = 0.
REQ-005 Clock and reset are one clock, clk, and a synchronous, active-high reset, rst. This is fixed.

Function
REQ-006 Single-port memory is shared between fetch (I) and data (D) requesters; at most one grant per cycle.
REQ-007 Grants are combinational from the current requests and registered state; mem_en = i_gnt | d_gnt; mem_addr, mem_we and mem_wdata come from the granted requester.
REQ-008 Requesters hold req and its payload stable until gnt; a request without gnt in a cycle is not consumed.
REQ-009 Owner FSM states: IDLE, I_OWN, D_OWN. Next state:
- I_OWN if i_gnt.
- D_OWN if d_gnt.
- IDLE otherwise.
The state records the last grantee for read-data routing.
REQ-010 Priority: D beats I (the older pipeline stage), subject to REQ-017.
REQ-011 Read latency is exactly 1 cycle. A granted read in cycle N gives the owner's rvalid = 1 and rdata = mem_rdata in cycle N+1. The other requester's rvalid is 0.
REQ-012 A granted store produces no rvalid. mem_we = 1 only in the cycle d_gnt & d_we.
REQ-013 Back-to-back grants are allowed every cycle. A read return in N+1 coexists with a new grant in N+1.
REQ-014 halt = 1: i_gnt = d_gnt = 0 and mem_en = 0. A read granted in the previous cycle still returns.
REQ-015 Address arithmetic: none. Addresses pass through unmodified; out-of-range values are the memory's concern.
REQ-016 i_rdata and d_rdata hold their last value when their rvalid is 0.

Configuration
REQ-017 Macro MIPS32_ARB_FAIRNESS_EN.
- Defined: a saturating counter starve_cnt (width clog2(STARVE_MAX+1)) increments on each d_gnt while i_req is pending. It clears on i_gnt, or when i_req = 0.
- Defined: when starve_cnt == STARVE_MAX and i_req = 1, I wins over D for one grant.
- Not defined: strict D priority, no counter, and I may starve indefinitely.

Reset
REQ-018 During rst = 1, all grants, mem_en, mem_we, i_rvalid and d_rvalid are 0.
REQ-019 After reset: FSM = IDLE, starve_cnt = 0, rdata registers = 0.
REQ-020 Reset asserted the cycle after a read grant suppresses that rvalid. The read is discarded.
REQ-021 The first grant is possible in the first cycle with rst = 0.

Structure
REQ-022 Package mips32_pkg holds:
- Owner state enum (IDLE, I_OWN, D_OWN).
- Default ADDR_W and DATA_W constants.
- Instruction opcode and type constants shared with the pipeline.
REQ-023 One natural sub-module: mips32_starve_ctr (saturating counter plus threshold compare), instantiated only under MIPS32_ARB_FAIRNESS_EN.

Verification
REQ-024 Only i_req = 1, addr 0x005, mem word 0xDEADBEEF -> i_gnt in cycle N; i_rvalid = 1, i_rdata = 0xDEADBEEF in N+1; d_rvalid = 0.
REQ-025 Same-cycle i_req and d_req (load 0x010) -> d_gnt first; i_gnt next cycle; rvalid is routed to each owner in turn.
REQ-026 Store d_addr 0x020, d_wdata 0x12345678, then load 0x020 -> mem_we = 1 in one cycle only; no d_rvalid for the store; d_rvalid = 1 with 0x12345678 for the load.
REQ-027 With the macro defined and STARVE_MAX = 4, continuous d_req and i_req -> 4 D grants, then 1 I grant, repeating. Without the macro -> zero I grants over 20 cycles.
REQ-028 halt = 1 with both requests pending for 3 cycles -> no grants and mem_en = 0. A read granted just before halt still returns rvalid.
REQ-029 rst pulsed the cycle after a read grant -> no rvalid; outputs are at reset values; a grant is issued in the first cycle after rst deasserts.
